pre_pool_writer: RTL and testbench
==================================

PRE_POOL_WRITER -- requirements
Module: pre_pool_writer

Interface
REQ-001 clk  input  1  sole clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 PRE_START  input  1  one-cycle start pulse.
REQ-004 PRE_STATUS  output  1  1 while busy (any state except IDLE).
REQ-005 CFG_WRITE_START_ADDR  input  32  word address of first output word.
REQ-006 CFG_WIDTH / CFG_HEIGHT  input  9 each  input fmap size; WIDTH a multiple of 16, HEIGHT even.
REQ-007 CFG_NUM_KERNEL  input  10  number of output maps.
REQ-008 MAC_OUT  input  512  chunk: lane i = bits [16i+15:16i], signed 16-bit; lanes 0-15 row r cols c..c+15, lanes 16-31 row r+1 same cols.
REQ-009 PRE_TAKE_VLD  input  1  chunk valid from conv stage.
REQ-010 PRE_TAKE_RDY  output  1  chunk accepted when VLD&RDY on a rising edge.
REQ-011 PRE_REQ / PRE_CMD / PRE_ADDR  output  1 / 4 / 32  memory-controller request, command, word address.
REQ-012 MEM_PRE_SEL  input  1  controller grant to this block.
REQ-013 PRE_WR_BUF / PRE_DIN  output  1 / 32  controller write-buffer push strobe and data.
REQ-014 MEM_FIN  input  1  one-cycle completion pulse of granted command.

Function
REQ-015 States: IDLE, CFG, WAIT_IN, BUF, REQ, WAIT_FIN.
REQ-016 IDLE: PRE_START=1 -> CFG; START ignored in every other state.
REQ-017 CFG: latch all CFG_* inputs; total = NUM_KERNEL*(HEIGHT/2)*(WIDTH/16); address pointer = WRITE_START_ADDR; chunk count = 0; -> WAIT_IN, or -> IDLE if total = 0.
REQ-018 WAIT_IN: PRE_TAKE_RDY=1 (only here); on VLD&RDY register 8 pooled results; -> BUF.
REQ-019 Pooled value j (j=0..7) = max of ReLU of lanes 2j, 2j+1, 16+2j, 17+2j; ReLU maps negative values to 0; result is 16-bit unsigned, no saturation needed.
REQ-020 BUF: 4 consecutive cycles PRE_WR_BUF=1, PRE_DIN word k (k=0..3) = {pool[2k+1], pool[2k]}; -> REQ after k=3.
REQ-021 REQ: PRE_REQ=1, PRE_CMD=4'h2 (write 4-word burst), PRE_ADDR=pointer; held stable until MEM_PRE_SEL=1, then -> WAIT_FIN.
REQ-022 WAIT_FIN: PRE_REQ held 1, CMD/ADDR held; on MEM_FIN: pointer += 4, count += 1; if count+1 = total -> IDLE, else -> WAIT_IN; PRE_REQ drops the cycle after MEM_FIN.
REQ-023 MEM_FIN outside WAIT_FIN ignored; MEM_PRE_SEL outside REQ ignored.
REQ-024 Chunks are consumed strictly in arrival order; addresses strictly sequential, no per-row or per-kernel gaps.
REQ-025 Pointer wraps modulo 2^32 without error.
REQ-026 Outputs PRE_WR_BUF, PRE_REQ, PRE_TAKE_RDY are registered; no combinational path from inputs to outputs.
REQ-027 Latency: VLD&RDY edge -> first PRE_WR_BUF cycle = 1 cycle; last push -> PRE_REQ = 1 cycle.

Reset
REQ-028 rst=1 at any edge, including mid-burst: state IDLE; PRE_STATUS, PRE_TAKE_RDY, PRE_REQ, PRE_WR_BUF = 0; PRE_CMD = 0; PRE_ADDR, PRE_DIN = 0; count and pointer = 0; pooled registers = 0.
REQ-029 A partially pushed write buffer is abandoned on reset; no request is issued for it.

Verification
REQ-030 WIDTH=32, HEIGHT=2, NUM_KERNEL=1, WRITE_START_ADDR=0x100; 2 chunks, immediate grant, FIN 2 cycles later -> writes at 0x100 then 0x104; STATUS falls after 2nd FIN.
REQ-031 Chunk lanes 0..31 = -1,5,3,-7,... with lane 17 = 0x7FFF, all others negative -> pool[0]=0x7FFF if lane 17 in group 0, negative-only groups -> 0; PRE_DIN word 0 = {pool1,pool0}.
REQ-032 Grant delayed 10 cycles -> PRE_REQ, PRE_CMD=2, PRE_ADDR stable all 10 cycles; PRE_TAKE_RDY stays 0 while VLD held high.
REQ-033 NUM_KERNEL=0, START pulse -> CFG then IDLE; no REQ, no WR_BUF, no RDY.
REQ-034 rst asserted during BUF cycle 2 -> next cycle all outputs 0, STATUS 0; new START with fresh config restarts at WRITE_START_ADDR.
REQ-035 START pulsed while in WAIT_FIN and spurious MEM_FIN in WAIT_IN -> no state, count or address change.

Source files
------------

// File: rtl/pre_pool_writer.sv
// Pre-pool writer: takes 2-row convolution chunks, applies ReLU and 2x2 max
// pooling to produce eight 16-bit results, packs them into a 4-word write
// burst and hands that burst to the memory controller at sequential addresses.
module pre_pool_writer (
  input  logic         clk,
  input  logic         rst,
  input  logic         PRE_START,
  output logic         PRE_STATUS,
  input  logic [31:0]  CFG_WRITE_START_ADDR,
  input  logic [8:0]   CFG_WIDTH,
  input  logic [8:0]   CFG_HEIGHT,
  input  logic [9:0]   CFG_NUM_KERNEL,
  input  logic [511:0] MAC_OUT,
  input  logic         PRE_TAKE_VLD,
  output logic         PRE_TAKE_RDY,
  output logic         PRE_REQ,
  output logic [3:0]   PRE_CMD,
  output logic [31:0]  PRE_ADDR,
  input  logic         MEM_PRE_SEL,
  output logic         PRE_WR_BUF,
  output logic [31:0]  PRE_DIN,
  input  logic         MEM_FIN
);

  typedef enum logic [2:0] {
    IDLE,
    CFG,
    WAIT_IN,
    BUF,
    REQ,
    WAIT_FIN
  } state_t;

  localparam logic [3:0] CMD_WRITE_BURST4 = 4'h2;

  state_t            state_q, state_d;
  logic [22:0]       total_q, total_d;
  logic [22:0]       count_q, count_d;
  logic [31:0]       ptr_q, ptr_d;
  logic [1:0]        beat_q, beat_d;
  logic [7:0][15:0]  pool_q, pool_d;
  logic              status_q, status_d;
  logic              rdy_q, rdy_d;
  logic              wr_buf_q, wr_buf_d;
  logic              req_q, req_d;
  logic [3:0]        cmd_q, cmd_d;
  logic [31:0]       addr_q, addr_d;
  logic [31:0]       din_q, din_d;

  logic [22:0]       cfg_total;
  logic [7:0][15:0]  pooled;

  // Negative activations clamp to zero; positives pass through unchanged.
  function automatic logic [15:0] relu(input logic [15:0] v);
    return v[15] ? 16'd0 : v;
  endfunction

  function automatic logic [15:0] max2(input logic [15:0] a, input logic [15:0] b);
    return (a > b) ? a : b;
  endfunction

  // Number of 4-word bursts in the job: one per 2-row x 16-column chunk.
  assign cfg_total = 23'(CFG_NUM_KERNEL) * 23'(CFG_HEIGHT >> 1) * 23'(CFG_WIDTH >> 4);

  // 2x2 max pool over ReLU'd lanes: pooled j covers cols 2j,2j+1 of both rows.
  always_comb begin
    pooled = '0;
    for (int j = 0; j < 8; j++) begin
      pooled[j] = max2(max2(relu(MAC_OUT[16*(2*j)      +: 16]),
                            relu(MAC_OUT[16*(2*j+1)    +: 16])),
                       max2(relu(MAC_OUT[16*(16+2*j)   +: 16]),
                            relu(MAC_OUT[16*(17+2*j)   +: 16])));
    end
  end

  // Next-state logic plus next values of every registered output.
  always_comb begin
    state_d = state_q;
    total_d = total_q;
    count_d = count_q;
    ptr_d   = ptr_q;
    beat_d  = beat_q;
    pool_d  = pool_q;

    case (state_q)
      IDLE: begin
        if (PRE_START) begin
          state_d = CFG;
        end
      end
      CFG: begin
        total_d = cfg_total;
        ptr_d   = CFG_WRITE_START_ADDR;
        count_d = '0;
        state_d = (cfg_total == '0) ? IDLE : WAIT_IN;
      end
      WAIT_IN: begin
        if (PRE_TAKE_VLD && rdy_q) begin
          pool_d  = pooled;
          beat_d  = '0;
          state_d = BUF;
        end
      end
      BUF: begin
        beat_d = beat_q + 2'd1;
        if (beat_q == 2'd3) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (MEM_PRE_SEL) begin
          state_d = WAIT_FIN;
        end
      end
      WAIT_FIN: begin
        if (MEM_FIN) begin
          ptr_d   = ptr_q + 32'd4;
          count_d = count_q + 23'd1;
          state_d = ((count_q + 23'd1) == total_q) ? IDLE : WAIT_IN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    status_d = (state_d != IDLE);
    rdy_d    = (state_d == WAIT_IN);
    wr_buf_d = (state_d == BUF);
    req_d    = (state_d == REQ) || (state_d == WAIT_FIN);
    cmd_d    = req_d ? CMD_WRITE_BURST4 : 4'h0;
    addr_d   = req_d ? ptr_d : 32'h0;
    din_d    = wr_buf_d ? {pool_d[{beat_d, 1'b1}], pool_d[{beat_d, 1'b0}]} : 32'h0;
  end

  // State and output registers; reset abandons any partially pushed burst.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      total_q  <= '0;
      count_q  <= '0;
      ptr_q    <= '0;
      beat_q   <= '0;
      pool_q   <= '0;
      status_q <= 1'b0;
      rdy_q    <= 1'b0;
      wr_buf_q <= 1'b0;
      req_q    <= 1'b0;
      cmd_q    <= 4'h0;
      addr_q   <= 32'h0;
      din_q    <= 32'h0;
    end else begin
      state_q  <= state_d;
      total_q  <= total_d;
      count_q  <= count_d;
      ptr_q    <= ptr_d;
      beat_q   <= beat_d;
      pool_q   <= pool_d;
      status_q <= status_d;
      rdy_q    <= rdy_d;
      wr_buf_q <= wr_buf_d;
      req_q    <= req_d;
      cmd_q    <= cmd_d;
      addr_q   <= addr_d;
      din_q    <= din_d;
    end
  end

  assign PRE_STATUS   = status_q;
  assign PRE_TAKE_RDY = rdy_q;
  assign PRE_WR_BUF   = wr_buf_q;
  assign PRE_REQ      = req_q;
  assign PRE_CMD      = cmd_q;
  assign PRE_ADDR     = addr_q;
  assign PRE_DIN      = din_q;

endmodule

// File: tb/tb_pre_pool_writer.sv
// Testbench for pre_pool_writer: random chunks and controller timing, checked
// against a pooling/addressing model derived from the block's rules.
module tb_pre_pool_writer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         pre_start = 1'b0;
  logic         pre_status;
  logic [31:0]  cfg_addr = '0;
  logic [8:0]   cfg_w = '0;
  logic [8:0]   cfg_h = '0;
  logic [9:0]   cfg_nk = '0;
  logic [511:0] mac_out = '0;
  logic         take_vld = 1'b0;
  logic         take_rdy;
  logic         pre_req;
  logic [3:0]   pre_cmd;
  logic [31:0]  pre_addr;
  logic         mem_sel = 1'b0;
  logic         wr_buf;
  logic [31:0]  pre_din;
  logic         mem_fin = 1'b0;

  int checks = 0;
  int errors = 0;
  logic [511:0] chunks [0:63];

  always #5 clk = ~clk;

  pre_pool_writer dut (
    .clk                  (clk),
    .rst                  (rst),
    .PRE_START            (pre_start),
    .PRE_STATUS           (pre_status),
    .CFG_WRITE_START_ADDR (cfg_addr),
    .CFG_WIDTH            (cfg_w),
    .CFG_HEIGHT           (cfg_h),
    .CFG_NUM_KERNEL       (cfg_nk),
    .MAC_OUT              (mac_out),
    .PRE_TAKE_VLD         (take_vld),
    .PRE_TAKE_RDY         (take_rdy),
    .PRE_REQ              (pre_req),
    .PRE_CMD              (pre_cmd),
    .PRE_ADDR             (pre_addr),
    .MEM_PRE_SEL          (mem_sel),
    .PRE_WR_BUF           (wr_buf),
    .PRE_DIN              (pre_din),
    .MEM_FIN              (mem_fin)
  );

  // Count one comparison and report it if it disagrees.
  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
    end
  endtask

  // Advance to a sampling point safely after the rising edge.
  task automatic stepCycle();
    @(posedge clk);
    #1;
  endtask

  // Reference: word k holds pooled results 2k (low half) and 2k+1 (high half).
  function automatic logic [31:0] modelWord(input logic [511:0] c, input int k);
    int best [2];
    int j;
    int lane;
    logic signed [15:0] raw;
    for (int h = 0; h < 2; h++) begin
      j = 2 * k + h;
      best[h] = 0;
      for (int n = 0; n < 4; n++) begin
        lane = (n < 2) ? (2 * j + n) : (16 + 2 * j + n - 2);
        raw = c[16*lane +: 16];
        if (int'(raw) > best[h]) best[h] = int'(raw);
      end
    end
    return {16'(best[1]), 16'(best[0])};
  endfunction

  function automatic logic [511:0] randomChunk();
    logic [511:0] c;
    for (int i = 0; i < 16; i++) c[32*i +: 32] = $urandom;
    return c;
  endfunction

  // Mostly-negative chunk with one large positive lane in the first group.
  function automatic logic [511:0] directedChunk();
    logic [511:0] c;
    for (int i = 0; i < 32; i++) c[16*i +: 16] = 16'h8000 + 16'(i);
    c[16*0  +: 16] = 16'hFFFF;
    c[16*1  +: 16] = 16'h0005;
    c[16*2  +: 16] = 16'h0003;
    c[16*3  +: 16] = 16'hFFF9;
    c[16*17 +: 16] = 16'h7FFF;
    return c;
  endfunction

  // Run one job: feed chunks, play memory controller, check every push and request.
  task automatic applyStimulus(input logic [31:0] start_addr, input int w, input int h, input int nk,
                               input int grant_delay, input int fin_delay,
                               input bit directed, input bit vld_always, input bit abort_mid);
    int total, chunk_idx, burst_idx, push_cnt, cycles, grant_wait, fin_wait, activity;
    bit req_active, granted, expect_wr, expect_req, expect_req_drop, aborted;
    logic [31:0] exp_addr;

    total = nk * (h / 2) * (w / 16);
    for (int i = 0; i < total; i++) chunks[i] = (directed && i == 0) ? directedChunk() : randomChunk();
    chunk_idx = 0; burst_idx = 0; push_cnt = 0; cycles = 0; grant_wait = 0; fin_wait = 0;
    req_active = 0; granted = 0; expect_wr = 0; expect_req = 0; expect_req_drop = 0; aborted = 0;

    cfg_addr = start_addr;
    cfg_w = 9'(w);
    cfg_h = 9'(h);
    cfg_nk = 10'(nk);
    pre_start = 1'b1;

    while (burst_idx < total && cycles < 3000 && !aborted) begin
      stepCycle();
      cycles++;
      pre_start = 1'b0;

      if (expect_wr) begin
        checkOutput("wr_latency", 32'(wr_buf), 32'd1);
        expect_wr = 0;
      end
      if (expect_req) begin
        checkOutput("req_after_push", 32'(pre_req), 32'd1);
        expect_req = 0;
      end
      if (expect_req_drop) begin
        checkOutput("req_drop", 32'(pre_req), 32'd0);
        expect_req_drop = 0;
      end

      if (wr_buf) begin
        if (directed && burst_idx == 0 && push_cnt == 0)
          checkOutput("word0_const", pre_din, 32'h0003_7FFF);
        checkOutput("din", pre_din, modelWord(chunks[burst_idx], push_cnt & 3));
        push_cnt++;
        if (push_cnt == 4) expect_req = 1;
        if (abort_mid && push_cnt == 2) begin
          rst = 1'b1;
          aborted = 1;
        end
      end

      if (pre_req && !aborted) begin
        exp_addr = start_addr + 32'(burst_idx * 4);
        if (!req_active) begin
          checkOutput("req_addr", pre_addr, exp_addr);
          checkOutput("req_cmd", 32'(pre_cmd), 32'h2);
          checkOutput("push_count", 32'(push_cnt), 32'd4);
          push_cnt = 0;
          req_active = 1;
          granted = 0;
          grant_wait = (grant_delay < 0) ? int'($urandom_range(0, 4)) : grant_delay;
        end else begin
          checkOutput("addr_hold", pre_addr, exp_addr);
          checkOutput("cmd_hold", 32'(pre_cmd), 32'h2);
          checkOutput("rdy_low", 32'(take_rdy), 32'd0);
        end
      end

      if (aborted) begin
        take_vld = 1'b0;
        mem_sel = 1'b0;
        mem_fin = 1'b0;
        pre_start = 1'b0;
      end else begin
        mem_sel = 1'b0;
        mem_fin = 1'b0;
        if (req_active && !granted) begin
          if (grant_wait == 0) begin
            mem_sel = 1'b1;
            granted = 1;
            fin_wait = (fin_delay < 0) ? int'($urandom_range(0, 3)) : fin_delay;
          end else begin
            grant_wait--;
          end
        end else if (req_active && granted) begin
          mem_sel = 1'($urandom % 2);
          if (fin_wait == 0) begin
            mem_fin = 1'b1;
            req_active = 0;
            granted = 0;
            burst_idx++;
            expect_req_drop = 1;
          end else begin
            fin_wait--;
          end
        end else begin
          mem_sel = ($urandom % 4 == 0);
          mem_fin = ($urandom % 4 == 0);
        end

        if (chunk_idx < total) begin
          take_vld = vld_always ? 1'b1 : ($urandom % 4 != 0);
          mac_out = chunks[chunk_idx];
        end else begin
          take_vld = 1'b0;
          mac_out = randomChunk();
        end
        if (take_vld && take_rdy) begin
          checkOutput("order", 32'(chunk_idx), 32'(burst_idx));
          chunk_idx++;
          expect_wr = 1;
        end

        pre_start = pre_status ? ($urandom % 8 == 0) : 1'b0;
      end
    end

    if (aborted) begin
      stepCycle();
      checkOutput("rst_status", 32'(pre_status), 32'd0);
      checkOutput("rst_rdy", 32'(take_rdy), 32'd0);
      checkOutput("rst_req", 32'(pre_req), 32'd0);
      checkOutput("rst_wr_buf", 32'(wr_buf), 32'd0);
      checkOutput("rst_cmd", 32'(pre_cmd), 32'd0);
      checkOutput("rst_addr", pre_addr, 32'd0);
      checkOutput("rst_din", pre_din, 32'd0);
      rst = 1'b0;
      activity = 0;
      for (int i = 0; i < 6; i++) begin
        stepCycle();
        if (pre_req || wr_buf || take_rdy || pre_status) activity++;
      end
      checkOutput("abort_quiet", 32'(activity), 32'd0);
    end else begin
      stepCycle();
      pre_start = 1'b0;
      mem_fin = 1'b0;
      mem_sel = 1'b0;
      take_vld = 1'b0;
      checkOutput("bursts_done", 32'(burst_idx), 32'(total));
      checkOutput("req_drop_end", 32'(pre_req), 32'd0);
      checkOutput("status_end", 32'(pre_status), 32'd0);
    end
  endtask

  // Directed scenarios first, then randomized jobs.
  initial begin
    int activity;
    $display("[TB] start");
    rst = 1'b1;
    stepCycle();
    stepCycle();
    checkOutput("reset_status", 32'(pre_status), 32'd0);
    checkOutput("reset_rdy", 32'(take_rdy), 32'd0);
    checkOutput("reset_req", 32'(pre_req), 32'd0);
    checkOutput("reset_wr_buf", 32'(wr_buf), 32'd0);
    checkOutput("reset_cmd", 32'(pre_cmd), 32'd0);
    checkOutput("reset_addr", pre_addr, 32'd0);
    checkOutput("reset_din", pre_din, 32'd0);
    rst = 1'b0;
    stepCycle();

    // Zero kernels: CFG then straight back to IDLE with no traffic.
    cfg_addr = 32'h0000_0400;
    cfg_w = 9'd32;
    cfg_h = 9'd2;
    cfg_nk = 10'd0;
    pre_start = 1'b1;
    stepCycle();
    pre_start = 1'b0;
    checkOutput("nk0_cfg_status", 32'(pre_status), 32'd1);
    activity = 0;
    stepCycle();
    checkOutput("nk0_idle_status", 32'(pre_status), 32'd0);
    for (int i = 0; i < 4; i++) begin
      if (pre_req || wr_buf || take_rdy || pre_status) activity++;
      stepCycle();
    end
    checkOutput("nk0_quiet", 32'(activity), 32'd0);

    // Two chunks at 0x100, immediate grant, FIN two cycles after grant.
    applyStimulus(32'h0000_0100, 32, 2, 1, 0, 1, 1'b1, 1'b0, 1'b0);
    // Long grant delay with VLD held high the whole time.
    applyStimulus(32'h0000_0800, 32, 2, 1, 10, 0, 1'b0, 1'b1, 1'b0);
    // Reset during the second push, then a fresh job from a new address.
    applyStimulus(32'h0000_1000, 16, 2, 2, 0, 0, 1'b0, 1'b1, 1'b1);
    applyStimulus(32'h0000_2000, 16, 2, 2, -1, -1, 1'b0, 1'b0, 1'b0);
    // Pointer wraps through zero.
    applyStimulus(32'hFFFF_FFF8, 32, 4, 1, -1, -1, 1'b0, 1'b0, 1'b0);

    for (int n = 0; n < 6; n++) begin
      applyStimulus($urandom, 16 * int'($urandom_range(1, 3)), 2 * int'($urandom_range(1, 2)),
                    int'($urandom_range(1, 2)), -1, -1, 1'b0, 1'($urandom % 2), 1'b0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
